// File: rtl/microfono.sv
// microfono: PDM audio record/playback block.
//
// Generates the PDM bit clock for a microphone, stores the 1-bit PDM stream
// into a DEPTH x 1 synchronous RAM while `rec` is held, and replays the
// stored take to a PDM amplifier on a rising edge of `play`.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   rec       in   record request (level)
//   play      in   playback request (rising edge)
//   bclk      out  PDM bit clock, 50% duty, CLK_DIV clocks per period
//   lrsel     out  mic channel select, tied 0
//   data_in   in   PDM data from microphone
//   data_out  out  PDM data to amplifier
//   ampSD     out  amplifier enable (0 = shutdown)
//   rd        out  high while playing
//   wr        out  high while recording
module microfono #(
  parameter int unsigned CLK_DIV = 40,
  parameter int unsigned ADDR_W  = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic rec,
  input  logic play,
  output logic bclk,
  output logic lrsel,
  input  logic data_in,
  output logic data_out,
  output logic ampSD,
  output logic rd,
  output logic wr
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned DivW  = $clog2(CLK_DIV);

  typedef logic [DivW-1:0]   div_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   len_t;

  localparam div_t DivLast = div_t'(CLK_DIV - 1);
  localparam div_t DivRise = div_t'(CLK_DIV / 2 - 1);
  localparam div_t DivHalf = div_t'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    StIdle,
    StRecord,
    StPlay
  } state_e;

  state_e state_q, state_d;
  div_t   div_q, div_d;
  addr_t  waddr_q, waddr_d;
  len_t   raddr_q, raddr_d;
  len_t   len_q, len_d;
  logic   bclk_q, bclk_d;
  logic   dout_q, dout_d;
  logic   play_q;
  logic   rec_block_q, rec_block_d;
  logic   wr_q, rd_q, amp_q;
  logic   rise_stb, fall_stb;
  logic   play_edge, rec_req;
  logic   mem_we;
  logic   rdata_q;

  // Sample memory; contents are deliberately not reset.
  logic mem [Depth];

  // ---------------------------------------------------------------------------
  // Bit-clock divider
  // ---------------------------------------------------------------------------
  always_comb begin
    div_d    = (div_q == DivLast) ? '0 : div_q + 1'b1;
    bclk_d   = (div_d >= DivHalf);
    rise_stb = (div_q == DivRise);
    fall_stb = (div_q == DivLast);
  end

  // A take that filled memory keeps `rec` from restarting until it is released.
  assign play_edge = play & ~play_q;
  assign rec_req   = rec & ~rec_block_q;

  // ---------------------------------------------------------------------------
  // Control FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    len_d       = len_q;
    dout_d      = dout_q;
    rec_block_d = rec_block_q & rec;
    mem_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        dout_d  = 1'b0;
        raddr_d = '0;
        if (rec_req) begin
          state_d = StRecord;
          waddr_d = '0;
        end else if (play_edge && (len_q != '0)) begin
          state_d = StPlay;
          raddr_d = '0;
        end
      end

      StRecord: begin
        dout_d = 1'b0;
        if (!rec) begin
          state_d = StIdle;
        end else if (rise_stb) begin
          mem_we  = 1'b1;
          waddr_d = waddr_q + 1'b1;
          len_d   = {1'b0, waddr_q} + 1'b1;
          if (waddr_q == '1) begin
            state_d     = StIdle;
            rec_block_d = 1'b1;
          end
        end
      end

      StPlay: begin
        if (fall_stb) begin
          // raddr == len means the last bit has now been held a full period.
          if (raddr_q == len_q) begin
            state_d = StIdle;
            dout_d  = 1'b0;
            raddr_d = '0;
          end else begin
            dout_d  = rdata_q;
            raddr_d = raddr_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        dout_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      div_q       <= '0;
      bclk_q      <= 1'b0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      len_q       <= '0;
      dout_q      <= 1'b0;
      play_q      <= 1'b0;
      rec_block_q <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      amp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      len_q       <= len_d;
      dout_q      <= dout_d;
      play_q      <= play;
      rec_block_q <= rec_block_d;
      wr_q        <= (state_d == StRecord);
      rd_q        <= (state_d == StPlay);
      amp_q       <= (state_d == StPlay);
    end
  end

  // ---------------------------------------------------------------------------
  // Synchronous RAM. The read port tracks raddr every clock, so the word for
  // the next fall strobe is always ready well before it is needed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr_q] <= data_in;
    end
    rdata_q <= mem[raddr_q[ADDR_W-1:0]];
  end

  assign bclk     = bclk_q;
  assign lrsel    = 1'b0;
  assign data_out = dout_q;
  assign ampSD    = amp_q;
  assign rd       = rd_q;
  assign wr       = wr_q;

endmodule

// File: tb/tb_microfono.sv
// Self-checking bench for microfono, run with a small divider and memory.
module tb_microfono;

  localparam int unsigned D     = 8;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rec = 1'b0;
  logic play = 1'b0;
  logic data_in = 1'b0;
  logic bclk, lrsel, data_out, ampSD, rd, wr;

  int errs = 0;
  int checks = 0;

  // Reference model: the bits of the last take, in order.
  bit take_q[$];

  int rec_cyc = 0;
  int wr_cyc = 0;

  microfono #(
    .CLK_DIV(D),
    .ADDR_W (AW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rec     (rec),
    .play    (play),
    .bclk    (bclk),
    .lrsel   (lrsel),
    .data_in (data_in),
    .data_out(data_out),
    .ampSD   (ampSD),
    .rd      (rd),
    .wr      (wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rec) rec_cyc++;
  always @(negedge clk) if (wr) wr_cyc++;

  typedef struct packed {
    logic rst;
    logic rec;
    logic play;
    logic wr;
    logic rd;
    logic amp;
    logic dout;
    logic bclk;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_wr"}, wr, 1'b0);
    chk({name, "_rd"}, rd, 1'b0);
    chk({name, "_amp"}, ampSD, 1'b0);
    chk({name, "_dout"}, data_out, 1'b0);
    chk({name, "_lrsel"}, lrsel, 1'b0);
  endtask

  // Wait (bounded) for bclk to transition to lvl; returns at the negedge after.
  task automatic wait_edge(input logic lvl);
    logic prev;
    for (int i = 0; i < 2 * D; i++) begin
      prev = bclk;
      step();
      if (prev !== lvl && bclk === lvl) return;
    end
    checks++;
    errs++;
    $display("FAIL bclk_edge_timeout: bclk never reached %b at %0t", lvl, $time);
  endtask

  // Count negedges until bclk leaves its current level.
  task automatic measure(input string name);
    logic lvl;
    int   n;
    lvl = bclk;
    n = 0;
    while (bclk === lvl && n < 4 * D) begin
      step();
      n++;
    end
    chk_rng(name, n, D / 2, D / 2);
  endtask

  // Record nbits bit periods with random data. Model: a bit is stored at each
  // bclk rise while fewer than DEPTH bits have been stored.
  task automatic record_take(input int nbits, input bit with_play, input bit full);
    int captured;
    captured = 0;
    take_q.delete();
    wait_edge(1'b0);
    data_in = 1'($urandom & 1);
    rec_cyc = 0;
    wr_cyc = 0;
    rec = 1'b1;
    play = with_play;
    step();
    chk("wr_rise", wr, 1'b1);
    chk("rd_in_rec", rd, 1'b0);
    play = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      wait_edge(1'b1);
      if (captured < DEPTH) begin
        take_q.push_back(data_in);
        captured++;
      end
      chk("wr_during_take", wr, (captured < DEPTH) ? 1'b1 : 1'b0);
      chk("rd_during_take", rd, 1'b0);
      if (k == 2) play = 1'b1;
      if (k == 3) play = 1'b0;
      wait_edge(1'b0);
      data_in = 1'($urandom & 1);
    end
    rec = 1'b0;
    step();
    chk("wr_fall", wr, 1'b0);
    chk("amp_in_rec", ampSD, 1'b0);
    if (!full) chk_rng("wr_len", wr_cyc, rec_cyc, rec_cyc);
  endtask

  // Play the stored take with play held high well past the end of playback.
  task automatic play_take();
    int  cnt;
    int  rdcyc;
    int  n;
    logic prev;
    logic exp;
    n = take_q.size();
    play = 1'b1;
    step();
    chk("rd_rise", rd, 1'b1);
    chk("amp_rise", ampSD, 1'b1);
    cnt = 0;
    rdcyc = 1;
    for (int i = 0; i < (n + 2) * D && rd === 1'b1; i++) begin
      prev = bclk;
      step();
      if (rd === 1'b1) begin
        rdcyc++;
        if (prev === 1'b1 && bclk === 1'b0) cnt++;
        exp = (cnt == 0) ? 1'b0 : take_q[cnt-1];
        if (cnt <= n) chk("play_bit", data_out, exp);
      end
    end
    chk_rng("play_bits", cnt, n, n);
    chk_rng("play_cycles", rdcyc, n * D + 1, (n + 1) * D);
    chk("rd_end", rd, 1'b0);
    chk("amp_end", ampSD, 1'b0);
    chk("dout_end", data_out, 1'b0);
    repeat (2 * D) step();
    chk("no_retrigger", rd, 1'b0);
    play = 1'b0;
    step();
  endtask

  initial begin
    tbl[0] = '{rst: 1, rec: 0, play: 0, wr: 0, rd: 0, amp: 0, dout: 0, bclk: 0};
    tbl[1] = '{rst: 0, rec: 0, play: 1, wr: 0, rd: 0, amp: 0, dout: 0, bclk: 0};
    tbl[2] = '{rst: 0, rec: 0, play: 0, wr: 0, rd: 0, amp: 0, dout: 0, bclk: 0};
    tbl[3] = '{rst: 0, rec: 1, play: 1, wr: 1, rd: 0, amp: 0, dout: 0, bclk: 0};
    tbl[4] = '{rst: 0, rec: 0, play: 1, wr: 0, rd: 0, amp: 0, dout: 0, bclk: 1};
    tbl[5] = '{rst: 1, rec: 0, play: 0, wr: 0, rd: 0, amp: 0, dout: 0, bclk: 0};

    reset = 1'b1;
    repeat (20) step();
    chk_idle("reset");
    chk("reset_bclk", bclk, 1'b0);

    // Per-cycle vectors straight out of reset: len=0 play ignored,
    // rec wins over a simultaneous play edge, bclk phase from div=0.
    for (int i = 0; i < 6; i++) begin
      reset = tbl[i].rst;
      rec   = tbl[i].rec;
      play  = tbl[i].play;
      step();
      chk($sformatf("vec%0d_wr", i), wr, tbl[i].wr);
      chk($sformatf("vec%0d_rd", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_amp", i), ampSD, tbl[i].amp);
      chk($sformatf("vec%0d_dout", i), data_out, tbl[i].dout);
      chk($sformatf("vec%0d_bclk", i), bclk, tbl[i].bclk);
    end
    reset = 1'b0;
    rec = 1'b0;
    play = 1'b0;
    step();

    // Bit clock duty and period.
    for (int p = 0; p < 3; p++) begin
      wait_edge(1'b1);
      measure("bclk_high");
      measure("bclk_low");
    end
    chk("lrsel", lrsel, 1'b0);

    // Short take, played twice.
    record_take(20, 1'b0, 1'b0);
    play_take();
    play_take();

    // rec and play rising together with a stored take: record wins.
    record_take(11, 1'b1, 1'b0);
    play_take();

    // Full-memory take with rec held beyond the end.
    record_take(DEPTH + 4, 1'b0, 1'b1);
    chk_rng("full_len", take_q.size(), DEPTH, DEPTH);
    wait_edge(1'b0);
    rec = 1'b1;
    step();
    chk("rec_after_full", wr, 1'b1);
    rec = 1'b0;
    step();
    chk("rec_after_full_off", wr, 1'b0);
    play_take();

    // Reset mid-playback discards the take.
    play = 1'b1;
    step();
    chk("mid_rd", rd, 1'b1);
    repeat (3 * D) step();
    reset = 1'b1;
    step();
    chk_idle("mid_reset");
    reset = 1'b0;
    play = 1'b0;
    step();
    play = 1'b1;
    step();
    step();
    chk("after_reset_rd", rd, 1'b0);
    chk("after_reset_amp", ampSD, 1'b0);
    play = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
